axi_burst_mem: RTL and testbench

AXI4 subordinate burst memory that sits directly downstream of the AXI memory-test manager and terminates its AW/W/B and AR/R channels. It is the on-chip target the tester writes bursts into and reads them back from.
Write and read paths are independent state machines over one shared word-addressed register array.
It supports INCR bursts of 1-256 beats at full bus width.

---
 rtl/axi_burst_mem.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_burst_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem.sv
// AXI4 subordinate burst memory: independent write (AW/W/B) and read (AR/R)
// state machines sharing one word-addressed array. INCR bursts only; other
// burst types are answered with SLVERR and leave memory untouched.
module axi_burst_mem #(
    parameter int unsigned AXI_ADDR_WIDTH      = 20,
    parameter int unsigned AXI_DATA_WIDTH      = 16,
    parameter int unsigned AXI_ID_WIDTH        = 4,
    parameter int unsigned AXI_STRB_WIDTH      = AXI_DATA_WIDTH / 8,
    parameter int unsigned MEM_WORD_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // write address
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    // write data
    input  logic                      s_axi_wvalid,
    input  logic                      s_axi_wlast,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                      s_axi_wready,
    // write response
    output logic                      s_axi_bvalid,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_bready,
    // read address
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    // read data
    output logic                      s_axi_rvalid,
    output logic                      s_axi_rlast,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    input  logic                      s_axi_rready
);

    localparam int unsigned AddrLsb    = $clog2(AXI_STRB_WIDTH);
    localparam int unsigned Depth      = 1 << MEM_WORD_ADDR_WIDTH;
    localparam logic [1:0]  BurstIncr  = 2'b01;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef logic [MEM_WORD_ADDR_WIDTH-1:0] idx_t;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [Depth];

    // Holds address-ready low until the first clock after reset release.
    logic rst_done_q;

    w_state_e                w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    idx_t                    w_idx_q, w_idx_d;
    logic [7:0]              w_len_q, w_len_d;
    logic [7:0]              w_cnt_q, w_cnt_d;
    logic                    w_err_q, w_err_d;
    logic                    w_mis_q, w_mis_d;  // sticky beat-count mismatch

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    idx_t                      r_idx_q, r_idx_d;
    logic [7:0]                r_left_q, r_left_d;  // beats still to follow the presented one
    logic                      r_err_q, r_err_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]                r_resp_q, r_resp_d;
    logic                      r_last_q, r_last_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    idx_t aw_idx, ar_idx;
    logic unused_inputs;

    assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize};

    assign aw_idx = s_axi_awaddr[AddrLsb +: MEM_WORD_ADDR_WIDTH];
    assign ar_idx = s_axi_araddr[AddrLsb +: MEM_WORD_ADDR_WIDTH];

    assign s_axi_awready = rst_done_q && (w_state_q == WIdle);
    assign s_axi_wready  = (w_state_q == WData);
    assign s_axi_bvalid  = (w_state_q == WResp);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = (s_axi_bvalid && (w_err_q || w_mis_q)) ? RespSlvErr : RespOkay;

    assign s_axi_arready = rst_done_q && (r_state_q == RIdle);
    assign s_axi_rvalid  = (r_state_q == RData);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = r_data_q;
    assign s_axi_rresp   = r_resp_q;
    assign s_axi_rlast   = r_last_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    // Write FSM next state: latch AW, count beats, flag mismatches, wait for B.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_mis_d   = w_mis_q;
        unique case (w_state_q)
            WIdle: begin
                if (aw_hs) begin
                    w_id_d    = s_axi_awid;
                    w_idx_d   = aw_idx;
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = (s_axi_awburst != BurstIncr);
                    w_mis_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (w_hs) begin
                    w_idx_d = w_idx_q + idx_t'(1);
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (s_axi_wlast) begin
                        if (w_cnt_q != w_len_q) w_mis_d = 1'b1;
                        w_state_d = WResp;
                    end else if (w_cnt_q == w_len_q) begin
                        // This beat should have carried wlast.
                        w_mis_d = 1'b1;
                    end
                end
            end
            WResp: begin
                if (b_hs) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read FSM next state: fetch one beat ahead into the registered R outputs.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_left_d  = r_left_q;
        r_err_d   = r_err_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        unique case (r_state_q)
            RIdle: begin
                if (ar_hs) begin
                    r_id_d    = s_axi_arid;
                    r_err_d   = (s_axi_arburst != BurstIncr);
                    r_data_d  = (s_axi_arburst != BurstIncr) ? '0 : mem_q[ar_idx];
                    r_resp_d  = (s_axi_arburst != BurstIncr) ? RespSlvErr : RespOkay;
                    r_idx_d   = ar_idx + idx_t'(1);
                    r_left_d  = s_axi_arlen;
                    r_last_d  = (s_axi_arlen == 8'd0);
                    r_state_d = RData;
                end
            end
            RData: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        r_last_d  = 1'b0;
                        r_state_d = RIdle;
                    end else begin
                        r_data_d = r_err_q ? '0 : mem_q[r_idx_q];
                        r_idx_d  = r_idx_q + idx_t'(1);
                        r_left_d = r_left_q - 8'd1;
                        r_last_d = (r_left_q == 8'd1);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Control state registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            w_state_q  <= WIdle;
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            w_mis_q    <= 1'b0;
            r_state_q  <= RIdle;
            r_id_q     <= '0;
            r_idx_q    <= '0;
            r_left_q   <= '0;
            r_err_q    <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RespOkay;
            r_last_q   <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            w_mis_q    <= w_mis_d;
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_idx_q    <= r_idx_d;
            r_left_q   <= r_left_d;
            r_err_q    <= r_err_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    // Byte-masked array write; contents survive reset, and a same-cycle read
    // fetch sees the old word because it samples before this update lands.
    always_ff @(posedge clk) begin
        if (w_hs && !w_err_q) begin
            for (int b = 0; b < int'(AXI_STRB_WIDTH); b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_mem.sv
// Self-checking bench for axi_burst_mem: directed and randomized bursts checked
// against a word-array reference model of the memory.
module tb_axi_burst_mem;

    localparam int AW = 20, DW = 16, IW = 4, SW = 2, DEPTH = 1024;

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_axi_awvalid = 0, s_axi_awready;
    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0] s_axi_awlen = '0;
    logic [2:0] s_axi_awsize = 3'd1;
    logic [1:0] s_axi_awburst = 2'b01;
    logic s_axi_wvalid = 0, s_axi_wlast = 0, s_axi_wready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic s_axi_bvalid, s_axi_bready = 1;
    logic [IW-1:0] s_axi_bid;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic s_axi_arvalid = 0, s_axi_arready;
    logic [IW-1:0] s_axi_arid = '0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0] s_axi_arlen = '0;
    logic [2:0] s_axi_arsize = 3'd1;
    logic [1:0] s_axi_arburst = 2'b01;
    logic s_axi_rvalid, s_axi_rlast, s_axi_rready = 1;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;

    axi_burst_mem dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wlast(s_axi_wlast), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one entry per word; ref_ok marks fully known words.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_ok  [DEPTH];
    logic [DW-1:0] wbeats [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int widx(input int addr);
        return (addr / SW) % DEPTH;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0: return s_axi_awready;
            1: return s_axi_wready;
            2: return s_axi_bvalid;
            3: return s_axi_arready;
            default: return s_axi_rvalid;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input string tag);
        int n = 0;
        while (!sig(sel) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) chk({tag, "_timeout"}, 32'(sig(sel)), 1);
    endtask

    // Drives AW then nsend beats of wbeats; awlen = len. Checks B and updates model.
    task automatic write_burst(input int addr, input int len, input logic [1:0] burst,
                               input logic [1:0] strb, input int nsend, input logic [3:0] id);
        bit err;
        @(negedge clk);
        s_axi_awvalid = 1; s_axi_awaddr = AW'(addr); s_axi_awlen = 8'(len);
        s_axi_awburst = burst; s_axi_awid = id;
        wait_hi(0, "awready");
        @(negedge clk);
        s_axi_awvalid = 0;
        for (int i = 0; i < nsend; i++) begin
            s_axi_wvalid = 1; s_axi_wdata = wbeats[i]; s_axi_wstrb = strb;
            s_axi_wlast = (i == nsend - 1);
            wait_hi(1, "wready");
            @(negedge clk);
        end
        s_axi_wvalid = 0; s_axi_wlast = 0;
        err = (burst != 2'b01) || (nsend != len + 1);
        wait_hi(2, "bvalid");
        chk("bid", 32'(s_axi_bid), 32'(id));
        chk("bresp", 32'(s_axi_bresp), err ? 32'h2 : 32'h0);
        @(negedge clk);
        chk("bvalid_drop", 32'(s_axi_bvalid), 0);
        chk("awready_back", 32'(s_axi_awready), 1);
        if (burst == 2'b01) begin
            for (int i = 0; i < nsend; i++) begin
                int k = (widx(addr) + i) % DEPTH;
                if (strb[0]) ref_mem[k][7:0] = wbeats[i][7:0];
                if (strb[1]) ref_mem[k][15:8] = wbeats[i][15:8];
                if (strb == 2'b11) ref_ok[k] = 1;
            end
        end
    endtask

    // Reads len+1 beats; stalls rready for 4 cycles on beat stall_beat (if >= 0).
    task automatic read_burst(input int addr, input int len, input logic [1:0] burst,
                              input logic [3:0] id, input int stall_beat);
        bit err = (burst != 2'b01);
        logic [DW-1:0] hd;
        logic hl;
        @(negedge clk);
        s_axi_arvalid = 1; s_axi_araddr = AW'(addr); s_axi_arlen = 8'(len);
        s_axi_arburst = burst; s_axi_arid = id; s_axi_rready = 1;
        wait_hi(3, "arready");
        @(negedge clk);
        s_axi_arvalid = 0;
        for (int i = 0; i <= len; i++) begin
            int k = (widx(addr) + i) % DEPTH;
            chk($sformatf("rvalid_b%0d", i), 32'(s_axi_rvalid), 1);
            if (i == stall_beat) begin
                s_axi_rready = 0;
                hd = s_axi_rdata; hl = s_axi_rlast;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_rdata", 32'(s_axi_rdata), 32'(hd));
                    chk("stall_rlast", 32'(s_axi_rlast), 32'(hl));
                    chk("stall_rvalid", 32'(s_axi_rvalid), 1);
                end
                s_axi_rready = 1;
            end
            if (err) chk($sformatf("rdata_err_b%0d", i), 32'(s_axi_rdata), 0);
            else if (ref_ok[k])
                chk($sformatf("rdata_w%0d", k), 32'(s_axi_rdata), 32'(ref_mem[k]));
            chk("rresp", 32'(s_axi_rresp), err ? 32'h2 : 32'h0);
            chk("rid", 32'(s_axi_rid), 32'(id));
            chk($sformatf("rlast_b%0d", i), 32'(s_axi_rlast), 32'(i == len));
            @(negedge clk);
        end
        chk("rvalid_end", 32'(s_axi_rvalid), 0);
    endtask

    task automatic fill_random(input int n);
        wbeats.delete();
        for (int i = 0; i < n; i++) wbeats.push_back(DW'($urandom));
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr, len;
        logic [3:0] id;
        for (int i = 0; i < DEPTH; i++) ref_ok[i] = 0;

        // Outputs during reset
        #1;
        chk("rst_awready", 32'(s_axi_awready), 0);
        chk("rst_arready", 32'(s_axi_arready), 0);
        chk("rst_wready", 32'(s_axi_wready), 0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 0);
        chk("rst_bid", 32'(s_axi_bid), 0);
        chk("rst_rid", 32'(s_axi_rid), 0);
        chk("rst_bresp", 32'(s_axi_bresp), 0);
        chk("rst_rresp", 32'(s_axi_rresp), 0);
        chk("rst_rdata", 32'(s_axi_rdata), 0);
        chk("rst_rlast", 32'(s_axi_rlast), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_awready", 32'(s_axi_awready), 1);
        chk("post_rst_arready", 32'(s_axi_arready), 1);

        // Basic 3-beat burst
        wbeats = '{16'h00D0, 16'h00D1, 16'h00D2};
        write_burst(0, 2, 2'b01, 2'b11, 3, 4'h5);
        read_burst(0, 2, 2'b01, 4'h5, -1);

        // Eight back-to-back 3-beat bursts, then read them all
        for (int b = 0; b < 8; b++) begin
            fill_random(3);
            write_burst(6 * b, 2, 2'b01, 2'b11, 3, 4'(b));
        end
        for (int b = 0; b < 8; b++) read_burst(6 * b, 2, 2'b01, 4'(b + 3), -1);

        // Byte strobe merge
        wbeats = '{16'h1234};
        write_burst(16'h10, 0, 2'b01, 2'b11, 1, 4'h1);
        wbeats = '{16'hAB56};
        write_burst(16'h10, 0, 2'b01, 2'b01, 1, 4'h2);
        chk("model_merge", 32'(ref_mem[widx(16'h10)]), 32'h1256);
        read_burst(16'h10, 0, 2'b01, 4'h3, -1);

        // rready stall mid-burst
        fill_random(8);
        write_burst(16'h40, 7, 2'b01, 2'b11, 8, 4'h6);
        read_burst(16'h40, 7, 2'b01, 4'h7, 3);

        // Non-INCR write and read
        fill_random(2);
        write_burst(16'h80, 1, 2'b01, 2'b11, 2, 4'h8);
        fill_random(2);
        write_burst(16'h80, 1, 2'b00, 2'b11, 2, 4'h9);
        read_burst(16'h80, 1, 2'b01, 4'hA, -1);
        read_burst(16'h80, 3, 2'b10, 4'hB, -1);

        // Early wlast: SLVERR but data still lands
        fill_random(2);
        write_burst(16'hA0, 3, 2'b01, 2'b11, 2, 4'hC);
        read_burst(16'hA0, 1, 2'b01, 4'hC, -1);

        // Wrap at the top of memory, with an out-of-range address
        fill_random(6);
        write_burst(20'h407FC, 5, 2'b01, 2'b11, 6, 4'hD);
        read_burst(16'h7FC, 5, 2'b01, 4'hD, 2);

        // Randomized bursts, including one of 256 beats
        for (int t = 0; t < 6; t++) begin
            addr = int'($urandom_range(0, 20'hFFFFF)) & ~1;
            len = (t == 5) ? 255 : int'($urandom_range(0, 15));
            id = 4'($urandom);
            fill_random(len + 1);
            write_burst(addr, len, 2'b01, 2'b11, len + 1, id);
            read_burst(addr, len, 2'b01, id, int'($urandom_range(0, len)));
        end

        // Reset during the second W beat
        fill_random(3);
        @(negedge clk);
        s_axi_awvalid = 1; s_axi_awaddr = 20'h100; s_axi_awlen = 8'd2;
        s_axi_awburst = 2'b01; s_axi_awid = 4'hE;
        wait_hi(0, "awready");
        @(negedge clk);
        s_axi_awvalid = 0;
        s_axi_wvalid = 1; s_axi_wdata = wbeats[0]; s_axi_wstrb = 2'b11; s_axi_wlast = 0;
        wait_hi(1, "wready");
        @(negedge clk);
        s_axi_wdata = wbeats[1];
        wait_hi(1, "wready");
        ref_mem[widx(20'h100)] = wbeats[0];
        ref_ok[widx(20'h100)] = 1;
        #2 rst_n = 0;
        #1;
        chk("midrst_awready", 32'(s_axi_awready), 0);
        chk("midrst_wready", 32'(s_axi_wready), 0);
        chk("midrst_bvalid", 32'(s_axi_bvalid), 0);
        chk("midrst_arready", 32'(s_axi_arready), 0);
        chk("midrst_rvalid", 32'(s_axi_rvalid), 0);
        repeat (2) @(negedge clk);
        s_axi_wvalid = 0;
        rst_n = 1;
        @(negedge clk);
        chk("relrst_awready", 32'(s_axi_awready), 1);
        chk("relrst_bvalid", 32'(s_axi_bvalid), 0);
        repeat (3) @(negedge clk);
        chk("relrst_no_b", 32'(s_axi_bvalid), 0);
        read_burst(20'h100, 0, 2'b01, 4'h1, -1);
        read_burst(0, 2, 2'b01, 4'h2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
